// File: rtl/grid_display_scanner.sv
// rtl/grid_display_scanner.sv - snapshots Life generations and row-scans them onto an 8x8 LED matrix
module grid_display_scanner #(
    parameter int DWELL_CYC = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid,
    input  logic        grid_valid,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic [6:0]  pop_count,
    output logic        stable,
    output logic        extinct
);

    localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    row;
    logic [63:0]   snap;
    logic [63:0]   pend;
    logic          pend_v;

    logic          wrap;
    logic          load;
    logic [63:0]   load_src;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            s = s + 7'(v[i]);
        end
        return s;
    endfunction

    // A strobe on the wrap edge itself is newer than anything pending.
    always_comb begin
        wrap     = (state == DRIVE) && (cnt == DWELL_LAST) && (row == 3'd7);
        load     = wrap && (grid_valid || pend_v);
        load_src = grid_valid ? grid : pend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap       <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            row        <= '0;
            state      <= BLANK;
            cnt        <= '0;
            row_sel    <= '0;
            col_data   <= '0;
            frame_done <= 1'b0;
            pop_count  <= '0;
            stable     <= 1'b0;
            extinct    <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            if (wrap) begin
                row        <= '0;
                state      <= BLANK;
                cnt        <= '0;
                row_sel    <= '0;
                col_data   <= '0;
                frame_done <= 1'b1;
                if (load) begin
                    snap      <= load_src;
                    pend_v    <= 1'b0;
                    pop_count <= popcount(load_src);
                    stable    <= (load_src == snap);
                    extinct   <= (load_src == 64'd0);
                end
            end else begin
                if (grid_valid) begin
                    pend   <= grid;
                    pend_v <= 1'b1;
                end
                case (state)
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state    <= DRIVE;
                            cnt      <= '0;
                            row_sel  <= 8'd1 << row;
                            col_data <= snap[{row, 3'b000} +: 8];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DRIVE: begin
                        if (cnt == DWELL_LAST) begin
                            state    <= BLANK;
                            cnt      <= '0;
                            row      <= row + 3'd1;
                            row_sel  <= '0;
                            col_data <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= BLANK;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grid_display_scanner.sv
// tb/tb_grid_display_scanner.sv - scoreboard bench for grid_display_scanner
module tb_grid_display_scanner;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int RP = DW + BL;
    localparam int FL = 8 * RP;

    typedef struct packed {
        logic [63:0] snap;
        logic [6:0]  pop;
        logic        stable;
        logic        extinct;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] grid = '0;
    logic        grid_valid = 1'b0;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic [6:0]  pop_count;
    logic        stable;
    logic        extinct;

    grid_display_scanner #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .grid       (grid),
        .grid_valid (grid_valid),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done),
        .pop_count  (pop_count),
        .stable     (stable),
        .extinct    (extinct)
    );

    always #5 clk = ~clk;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   done = 0;
    logic rst_q;

    always @(posedge clk) rst_q <= reset;

    // Frame-level reference: what the panel shows and the flags reported with it.
    logic [63:0] m_shown = '0;
    logic [6:0]  m_pop = '0;
    logic        m_stable = 1'b0;
    bit          plan_v[FL];
    logic [63:0] plan_g[FL];

    task automatic clear_plan();
        for (int i = 0; i < FL; i++) begin
            plan_v[i] = 0;
            plan_g[i] = '0;
        end
    endtask

    task automatic add(input int p, input logic [63:0] g);
        plan_v[p] = 1;
        plan_g[p] = g;
    endtask

    // Entered and left on the negedge of a frame's cycle 0.
    task automatic run_frame(input int abort_at);
        logic [63:0] last;
        bit          any;
        rec_t        r;
        any  = 0;
        last = '0;
        for (int p = 0; p < FL; p++) begin
            if (plan_v[p]) begin
                any  = 1;
                last = plan_g[p];
            end
        end
        if (abort_at < 0) begin
            if (any) begin
                m_stable = (last == m_shown);
                m_shown  = last;
                m_pop    = 7'($countones(last));
            end
            r = '{snap: m_shown, pop: m_pop, stable: m_stable, extinct: (m_shown == 64'd0)};
            sb.push_back(r);
        end
        for (int p = 0; p < FL; p++) begin
            if (p == abort_at) begin
                reset      = 1'b1;
                grid_valid = 1'b0;
                sb.delete();
                m_shown  = '0;
                m_pop    = '0;
                m_stable = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                clear_plan();
                return;
            end
            grid_valid = plan_v[p];
            grid       = plan_v[p] ? plan_g[p] : {$urandom, $urandom};
            @(negedge clk);
        end
        grid_valid = 1'b0;
        clear_plan();
    endtask

    // Monitor: expected scan position is derived from the frame geometry alone.
    initial begin
        rec_t       cur;
        int         pos;
        int         r;
        logic [7:0] e_rs, e_cd;
        logic       e_fd;
        pos = 0;
        cur = '{snap: 64'd0, pop: 7'd0, stable: 1'b0, extinct: 1'b1};
        do @(negedge clk); while (rst_q !== 1'b1);
        while (!done) begin
            if (rst_q) begin
                pos = 0;
                cur = '{snap: 64'd0, pop: 7'd0, stable: 1'b0, extinct: 1'b1};
            end else begin
                pos = (pos + 1) % FL;
                if (pos == 0) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_empty: frame wrap with no expected frame queued");
                    end else begin
                        cur = sb.pop_front();
                    end
                end
            end
            r    = pos / RP;
            e_fd = (pos == 0) && !rst_q;
            if ((pos % RP) >= BL) begin
                e_rs = 8'd1 << r;
                e_cd = cur.snap[8*r +: 8];
            end else begin
                e_rs = 8'd0;
                e_cd = 8'd0;
            end
            checks++;
            if (row_sel !== e_rs || col_data !== e_cd || frame_done !== e_fd ||
                pop_count !== cur.pop || stable !== cur.stable || extinct !== cur.extinct) begin
                errors++;
                $display("FAIL scan pos=%0d: got rs=%h cd=%h fd=%b pop=%0d st=%b ex=%b, want rs=%h cd=%h fd=%b pop=%0d st=%b ex=%b",
                         pos, row_sel, col_data, frame_done, pop_count, stable, extinct,
                         e_rs, e_cd, e_fd, cur.pop, cur.stable, cur.extinct);
            end
            @(negedge clk);
        end
    end

    initial begin
        logic [63:0] g;
        int          n;
        clear_plan();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        add(5, 64'h8100_0000_0000_00FF);
        run_frame(-1);
        add(3, 64'hAAAA_AAAA_AAAA_AAAA);
        add(20, 64'h5555_5555_5555_5555);
        add(40, 64'h0F0F_0F0F_0F0F_0F0F);
        run_frame(-1);
        add(7, 64'h0123_4567_89AB_CDEF);
        run_frame(-1);
        add(30, 64'h0123_4567_89AB_CDEF);
        run_frame(-1);
        add(12, 64'd0);
        run_frame(-1);
        add(10, 64'hDEAD_BEEF_0000_1111);
        add(FL - 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_frame(-1);
        run_frame(-1);
        add(10, 64'h1234_0000_5678_0000);
        run_frame(4 * RP + BL + 1);
        run_frame(-1);
        add(FL - 1, 64'h0000_0000_0000_0180);
        run_frame(-1);

        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 3))
                    0:       g = m_shown;
                    1:       g = 64'd0;
                    default: g = {$urandom, $urandom};
                endcase
                add($urandom_range(0, FL - 1), g);
            end
            run_frame(-1);
        end
        run_frame(-1);

        done = 1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
